seq_mult_shift_add: RTL

Parametrised, multi-cycle shift-and-add multiplier that supports signed and unsigned operands. It replaces the single-cycle combinational 4-bit multiplier in the 8x8 multiplier family. It processes one multiplier bit per clock, which gives a small area footprint. The block sits between an operand-issuing controller and any result consumer, connected through a start/busy/done handshake.

---
 rtl/seq_mult_shift_add_if.sv | 28 ++
 rtl/seq_mult_shift_add.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seq_mult_shift_add_if.sv
// Operand/result handshake bundle for seq_mult_shift_add.
//   start       : request a multiply (controller -> multiplier)
//   signed_mode : 1 = two's-complement operands, 0 = unsigned
//   a, b        : multiplicand / multiplier, WIDTH bits each
//   busy        : operation in progress (multiplier -> controller)
//   done        : one-cycle pulse, result newly updated
//   result      : 2*WIDTH-bit product, held until the next completion
interface seq_mult_shift_add_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/seq_mult_shift_add.sv
// Multi-cycle shift-and-add multiplier, signed or unsigned operands.
// One multiplier bit is consumed per clock; a product is ready WIDTH
// cycles after the start is accepted.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : slave side of seq_mult_shift_add_if
//          (start/signed_mode/a/b in, busy/done/result out)
// Signed operands are converted to magnitudes on capture and the sign
// is re-applied once to the final accumulator.
module seq_mult_shift_add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_mult_shift_add_if.slave bus
);

  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mult;
  logic [CW-1:0]        cnt;
  logic                 neg;
  logic [2*WIDTH-1:0]   result_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 accept;
  logic                 last_iter;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [2*WIDTH-1:0]   prod;

  // ---------------------------------------------------------------
  // Next-state and datapath combinational terms
  // ---------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_iter = 1'b0;

    case (state)
      IDLE: begin
        accept = bus.start;
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        last_iter = (cnt == LAST);
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        // A start in the DONE cycle re-enters RUN without an IDLE gap.
        accept = bus.start;
        state_nxt = bus.start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mag_a = bus.a;
    mag_b = bus.b;
    // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct
    // unsigned magnitude in WIDTH bits.
    if (bus.signed_mode && bus.a[WIDTH-1]) mag_a = -bus.a;
    if (bus.signed_mode && bus.b[WIDTH-1]) mag_b = -bus.b;
  end

  always_comb begin
    acc_sum = acc;
    if (mult[0]) acc_sum = acc + mcand;
    prod = neg ? -acc_sum : acc_sum;
  end

  // ---------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      mcand    <= '0;
      mult     <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // Flags follow the next state so they line up with the state
      // register rather than lagging it by a cycle.
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);

      if (accept) begin
        mcand <= {{WIDTH{1'b0}}, mag_a};
        mult  <= mag_b;
        neg   <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        acc   <= '0;
        cnt   <= '0;
      end else if (state == RUN) begin
        acc   <= acc_sum;
        mcand <= mcand << 1;
        mult  <= mult >> 1;
        cnt   <= cnt + CW'(1);
        // The final partial product is folded in on the same edge the
        // result is published.
        if (last_iter) result_q <= prod;
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
